// File: rtl/spm_burst_ctrl.sv
// Burst front-end for one scratchpad port: write beats in, read beats out.
// Optional bounds rejection when SPM_BOUNDS_CHECK_EN is defined.
module spm_burst_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEMSIZE_KB = 128,
  parameter int LEN_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              done,
  output logic              busy,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int MEM_WORDS = MEMSIZE_KB * 1024 / 4;
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] cur, cur_n;
  logic [LEN_W-1:0]  len, cnt;
  logic              inflight, inflight_last;
  logic [DATA_W-1:0] fdata [2];
  logic [1:0]        flast;
  logic              wp, rp;
  logic [1:0]        fcnt, outstanding;
  logic              done_q, err_q, done_n;
  logic              accept, reject, beat, issue, pop, last_beat, drained;

  assign accept    = req_valid && (state == IDLE);
  assign last_beat = (cnt == len);
  assign cur_n     = (cur == LAST_WORD) ? '0 : cur + 1'b1;
  assign pop       = rd_valid && rd_ready;
  assign outstanding = fcnt + {1'b0, inflight};
  assign drained   = (fcnt == 2'd0) && !inflight;

`ifdef SPM_BOUNDS_CHECK_EN
  logic [ADDR_W:0] span;
  assign span   = {1'b0, req_addr} + (ADDR_W+1)'(req_len);
  assign reject = accept && (span > (ADDR_W+1)'(MEM_WORDS - 1));
`else
  assign reject = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    wr_ready  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    beat      = 1'b0;
    issue     = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !reject)
          state_n = req_write ? WRITE : READ;
      end
      WRITE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          beat     = 1'b1;
          mem_en   = 1'b1;
          mem_we   = 1'b1;
          mem_addr = cur;
          mem_din  = wr_data;
          if (last_beat) state_n = IDLE;
        end
      end
      READ: begin
        // A same-cycle pop frees a slot, keeping 1 beat/cycle at 2 deep
        if (outstanding < 2'd2 || (outstanding == 2'd2 && pop)) begin
          issue    = 1'b1;
          mem_en   = 1'b1;
          mem_addr = cur;
          if (last_beat) state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (drained) state_n = IDLE;
      end
    endcase
  end

  assign done_n = (beat && last_beat) || ((state == DRAIN) && drained) || reject;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cur           <= '0;
      len           <= '0;
      cnt           <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      flast         <= '0;
      wp            <= 1'b0;
      rp            <= 1'b0;
      fcnt          <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state         <= state_n;
      done_q        <= done_n;
      err_q         <= reject;
      inflight      <= issue;
      inflight_last <= issue && last_beat;
      if (accept && !reject) begin
        cur <= req_addr;
        len <= req_len;
        cnt <= '0;
      end else if (beat || issue) begin
        cur <= cur_n;
        cnt <= cnt + 1'b1;
      end
      if (inflight) begin
        flast[wp] <= inflight_last;
        wp        <= ~wp;
      end
      if (pop) rp <= ~rp;
      fcnt <= fcnt + {1'b0, inflight} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (inflight) fdata[wp] <= mem_dout;
  end

  assign rd_valid = (fcnt != 2'd0);
  assign rd_data  = fdata[rp];
  assign rd_last  = rd_valid && flast[rp];
  assign done     = done_q;
  assign err      = err_q;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_spm_burst_ctrl.sv
// Scoreboard bench for spm_burst_ctrl with a behavioural scratchpad port.
// Honours SPM_BOUNDS_CHECK_EN for the out-of-range request vector.
module tb_spm_burst_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int MW = 32768;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_len = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b1;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          done;
  logic          busy;
  logic          err;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout = '0;

  always #5 clk = ~clk;

  spm_burst_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .MEMSIZE_KB(128), .LEN_W(LW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_last(rd_last), .done(done), .busy(busy), .err(err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  logic [DW-1:0] smem [0:MW-1];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) smem[mem_addr[14:0]] <= mem_din;
      else        mem_dout <= smem[mem_addr[14:0]];
    end
  end

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  beat_t rq[$];
  wr_t   wq[$];
  logic  dq[$];

  int total = 0;
  int bad = 0;
  int issues = 0;
  int pops = 0;
  logic prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic toggle_mode = 1'b0;
  int ph = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic clear_sb();
    rq.delete();
    wq.delete();
    dq.delete();
    issues = 0;
    pops = 0;
    prev_stall = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (toggle_mode) begin
      rd_ready = (ph % 3 == 0);
      ph++;
    end else begin
      rd_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        check("rd_hold_valid", 32'(rd_valid), 32'd1);
        check("rd_hold_data", rd_data, prev_data);
      end
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
      if (mem_en && !mem_we) begin
        check("outstanding_le2",
              32'((issues - pops - ((rd_valid && rd_ready) ? 1 : 0) + 1) <= 2),
              32'd1);
        issues++;
      end
      if (rd_valid && rd_ready) begin
        pops++;
        if (rq.size() == 0) begin
          check("rd_unexpected_beat", rd_data, 32'hFFFF_FFFF);
        end else begin
          beat_t b;
          b = rq.pop_front();
          check("rd_data", rd_data, b.d);
          check("rd_last", 32'(rd_last), 32'(b.l));
        end
      end
      if (mem_en && mem_we) begin
        if (wq.size() == 0) begin
          check("wr_unexpected", mem_addr, 32'hFFFF_FFFF);
        end else begin
          wr_t w;
          w = wq.pop_front();
          check("wr_addr", mem_addr, w.a);
          check("wr_data", mem_din, w.d);
        end
      end
      if (done) begin
        if (dq.size() == 0) check("done_unexpected", 32'(done), 32'd0);
        else check("err_at_done", 32'(err), 32'(dq.pop_front()));
      end else if (err) begin
        check("err_without_done", 32'(err), 32'd0);
      end
    end
  end

  task automatic send_req(input logic w, input logic [31:0] a,
                          input logic [7:0] l);
    logic ok;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_len   = l;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) check("req_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_req_ready"}, 32'(req_ready), 32'd1);
        break;
      end
    end
    if (!seen) check({name, "_done_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic write_burst(input logic [31:0] a, input logic [7:0] l,
                             input logic [31:0] base);
    int n;
    int cyc;
    for (int i = 0; i <= int'(l); i++) begin
      wr_t w;
      w.a = 32'((int'(a) + i) % MW);
      w.d = base + 32'(i);
      wq.push_back(w);
    end
    dq.push_back(1'b0);
    send_req(1'b1, a, l);
    wr_valid = 1'b1;
    wr_data  = base;
    n = 0;
    cyc = 0;
    while (n <= int'(l) && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (wr_ready) n++;
      @(posedge clk);
      #1;
      wr_data = base + 32'(n);
    end
    wr_valid = 1'b0;
    check("wr_cycles", 32'(cyc), 32'(int'(l) + 1));
    wait_done("wr");
  endtask

  task automatic read_burst(input logic [31:0] a, input logic [7:0] l,
                            input logic [31:0] base);
    int lat;
    for (int i = 0; i <= int'(l); i++) begin
      beat_t b;
      b.d = base + 32'(i);
      b.l = (i == int'(l));
      rq.push_back(b);
    end
    dq.push_back(1'b0);
    send_req(1'b0, a, l);
    lat = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rd_valid) break;
      @(posedge clk);
      lat++;
    end
    check("rd_first_latency", 32'(lat), 32'd2);
    @(posedge clk);
    #1;
    wait_done("rd");
    check("rd_all_beats", 32'(rq.size()), 32'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_last", 32'(rd_last), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_din", mem_din, 32'd0);
    @(posedge clk);
    #1;

    write_burst(32'h10, 8'd3, 32'hA0);
    read_burst(32'h10, 8'd3, 32'hA0);

    toggle_mode = 1'b1;
    read_burst(32'h10, 8'd3, 32'hA0);
    toggle_mode = 1'b0;
    @(posedge clk);
    #1;

`ifdef SPM_BOUNDS_CHECK_EN
    begin
      int en_seen;
      int wr_seen;
      int done_seen;
      dq.push_back(1'b1);
      wr_valid = 1'b1;
      wr_data  = 32'hB0;
      send_req(1'b1, 32'(MW - 1), 8'd1);
      en_seen = 0;
      wr_seen = 0;
      done_seen = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (mem_en) en_seen++;
        if (wr_ready) wr_seen++;
        if (done) done_seen++;
        @(posedge clk);
        #1;
      end
      wr_valid = 1'b0;
      check("oob_mem_en_cycles", 32'(en_seen), 32'd0);
      check("oob_wr_ready_cycles", 32'(wr_seen), 32'd0);
      check("oob_done_pulses", 32'(done_seen), 32'd1);
      check("oob_busy", 32'(busy), 32'd0);
    end
`else
    write_burst(32'(MW - 1), 8'd1, 32'hB0);
    read_burst(32'(MW - 1), 8'd1, 32'hB0);
`endif

    write_burst(32'h20, 8'd7, 32'hC0);
    clear_sb();
    for (int i = 0; i < 8; i++) begin
      beat_t b;
      b.d = 32'hC0 + 32'(i);
      b.l = (i == 7);
      rq.push_back(b);
    end
    dq.push_back(1'b0);
    send_req(1'b0, 32'h20, 8'd7);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (pops >= 2) break;
    end
    check("midrst_pops", 32'(pops), 32'd2);
    rst = 1'b1;
    clear_sb();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_rd_valid", 32'(rd_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    read_burst(32'h20, 8'd0, 32'hC0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
